booth_mult_sequencer: RTL and testbench

//  - Sequences the radix-2 Booth step datapath (one add/sub/hold + arithmetic shift per step) to form a full signed product.
//  - Owns the 65-bit product register, the multiplicand register and the step counter.
//  - Accepts one request per operation; returns the low word, the high word and an overflow flag.
//  - Sits between the execute stage (start/operands in, result/valid out) and the step datapath.

---
 rtl/booth_mult_sequencer.sv | 103 ++++++++++
 tb/tb_booth_mult_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sequencer.sv
// Sequencer for a radix-2 Booth multiplier: owns the product/multiplicand/step-count state
// and steps an external datapath 32 times per request. `MULT_ABORT_EN adds an abort input.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for start; last result held on result_*
// RUN   | one Booth step per edge, product taken from step_next
// DONE  | result_valid pulse; start here reloads with no idle bubble
module booth_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
`ifdef MULT_ABORT_EN
    input  logic               abort,
`endif
    output logic [2*WIDTH:0]   step_prod,
    output logic [WIDTH-1:0]   step_mcand,
    input  logic [2*WIDTH:0]   step_next,
    output logic               busy,
    output logic               result_valid,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi,
    output logic               overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [2*WIDTH:0]   prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               abort_hit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            prod_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        abort_hit = 1'b0;
`ifdef MULT_ABORT_EN
        abort_hit = abort;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    prod_d  = {{WIDTH{1'b0}}, operand_a, 1'b0};
                    mcand_d = operand_b;
                    count_d = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // An aborted operation leaves the partial product untouched.
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d  = step_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign step_prod    = prod_q;
    assign step_mcand   = mcand_q;
    assign busy         = (state_q == ST_RUN);
    assign result_valid = (state_q == ST_DONE);
    assign result_lo    = prod_q[WIDTH:1];
    assign result_hi    = prod_q[2*WIDTH:WIDTH+1];
    assign overflow     = (result_hi != {WIDTH{result_lo[WIDTH-1]}});

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer: provides a Booth step datapath and compares
// results against a 64-bit signed product model. Define MULT_ABORT_EN to exercise abort.
`timescale 1ns/1ps

module tb_booth_mult_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] operand_a, operand_b;
    logic [64:0] step_prod, step_next;
    logic [31:0] step_mcand;
    logic        busy, result_valid, overflow;
    logic [31:0] result_lo, result_hi;
`ifdef MULT_ABORT_EN
    logic        abort;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned edge_cnt = 0, pulse_cnt = 0, busy_cnt = 0;
    int unsigned exp_pulses = 0, e0 = 0, b0 = 0;
    logic [31:0] exp_lo, exp_hi, exp_mcand;
    logic        exp_ovf;

    booth_mult_sequencer dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
`ifdef MULT_ABORT_EN
        .abort        (abort),
`endif
        .step_prod    (step_prod),
        .step_mcand   (step_mcand),
        .step_next    (step_next),
        .busy         (busy),
        .result_valid (result_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    // Booth step: add/sub on a sign-extended upper half, then arithmetic shift right by one.
    logic [32:0] acc;
    always_comb begin
        acc = {step_prod[64], step_prod[64:33]};
        case (step_prod[1:0])
            2'b01:   acc = acc + {step_mcand[31], step_mcand};
            2'b10:   acc = acc - {step_mcand[31], step_mcand};
            default: acc = acc;
        endcase
        step_next = {acc, step_prod[32:1]};
    end

    always @(posedge clock) begin
        edge_cnt++;
        if (result_valid) pulse_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        exp_lo    = p[31:0];
        exp_hi    = p[63:32];
        exp_ovf   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        exp_mcand = b;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        set_model(a, b);
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clock); #1;
        e0    = edge_cnt;
        b0    = busy_cnt;
        start = 1'b0;
        check("load_busy", busy, 1'b1);
        check("load_mcand", step_mcand, exp_mcand);
    endtask

    task automatic wait_result(input string tag);
        int cyc = 0;
        while (!result_valid && cyc < 100) begin
            operand_a = $urandom;
            operand_b = $urandom;
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_latency"}, edge_cnt - e0, 32);
        check({tag, "_busy_cycles"}, busy_cnt - b0, 32);
        check({tag, "_lo"}, result_lo, exp_lo);
        check({tag, "_hi"}, result_hi, exp_hi);
        check({tag, "_ovf"}, overflow, exp_ovf);
        if (result_valid) exp_pulses++;
    endtask

    task automatic finish_op(input string tag);
        @(posedge clock); #1;
        check({tag, "_valid_drop"}, result_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_hold_lo"}, result_lo, exp_lo);
        check({tag, "_hold_hi"}, result_hi, exp_hi);
    endtask

    task automatic idle_and_count(input string tag, input int n);
        repeat (n) @(posedge clock);
        #1;
        check({tag, "_pulses"}, pulse_cnt, exp_pulses);
    endtask

    initial begin
        logic [31:0] ra, rb;
        resetn    = 1'b0;
        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
`ifdef MULT_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_lo", result_lo, 32'h0);
        check("rst_hi", result_hi, 32'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_prod", step_prod, 65'h0);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("idle_busy", busy, 1'b0);

        start_op(32'd7, -32'sd3);
        wait_result("m7x-3");
        check("m7x-3_lo_const", result_lo, 32'hFFFF_FFEB);
        check("m7x-3_hi_const", result_hi, 32'hFFFF_FFFF);
        finish_op("m7x-3");

        start_op(32'h7FFF_FFFF, 32'd2);
        wait_result("max_x2");
        check("max_x2_ovf_const", overflow, 1'b1);
        finish_op("max_x2");

        start_op(32'h8000_0000, 32'h8000_0000);
        wait_result("minsq");
        check("minsq_hi_const", result_hi, 32'h4000_0000);
        check("minsq_lo_const", result_lo, 32'h0);
        finish_op("minsq");

        // start with new operands mid-run must be ignored
        start_op(32'd123456, -32'sd789);
        repeat (4) @(posedge clock);
        #1;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("e5_still_busy", busy, 1'b1);
        wait_result("e5_ignored");
        finish_op("e5_ignored");
        idle_and_count("e5_no_second", 40);

        // back-to-back: start driven during the DONE cycle
        start_op(32'd1000, 32'd3000);
        wait_result("b2b_first");
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("b2b_second");
        check("b2b_lo_const", result_lo, 32'd1);
        finish_op("b2b_second");

        // reset pulse in the middle of a run
        start_op(32'd55, 32'd66);
        repeat (9) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_lo", result_lo, 32'h0);
        check("midrst_hi", result_hi, 32'h0);
        check("midrst_ovf", overflow, 1'b0);
        @(posedge clock); #1;
        resetn = 1'b1;
        idle_and_count("midrst_no_valid", 40);
        start_op(-32'sd40000, 32'd70000);
        wait_result("after_rst");
        finish_op("after_rst");

`ifdef MULT_ABORT_EN
        start_op(32'd321, 32'd654);
        repeat (11) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", result_valid, 1'b0);
        idle_and_count("abort_no_valid", 40);

        start_op(32'd9, 32'd11);
        wait_result("abort_pre");
        abort = 1'b1;
        start_op(-32'sd5, 32'd17);
        abort = 1'b0;
        wait_result("abort_start_wins");
        finish_op("abort_start_wins");
`endif

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'h8000_0000;
            if (i == 2) ra = 32'h0;
            start_op(ra, rb);
            wait_result("rand");
            finish_op("rand");
        end

        idle_and_count("final", 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
